mdu_iter: RTL and testbench
===========================

# mdu_iter

Iterative multiply/divide unit for the pipelined MIPS core, owning the HI/LO register pair. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO with a start/busy/done handshake. It sits beside the ALU in the EX stage; the hazard logic stalls the pipeline while `busy` is high, and MFHI/MFLO read `hi`/`lo` directly. It generalises the fixed 32-bit, single-cycle ALU path to a parametrised `WIDTH`, and adds multi-cycle operation and flush support.

## Interface
- `WIDTH`, default 32: operand and HI/LO width. Must be even and ≥ 8.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `start`, input, 1: request an operation; sampled on the rising edge.
- `op`, input, 3: operation code. Values come from the package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- `a`, input, WIDTH: rs operand (dividend / multiplicand / MTHI/MTLO data).
- `b`, input, WIDTH: rt operand (divisor / multiplier).
- `flush`, input, 1: cancel the in-flight operation (branch/exception flush).
- `busy`, output, 1: registered; high while an operation is in flight.
- `done`, output, 1: registered; one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- `hi`, output, WIDTH: HI register (product upper half / remainder).
- `lo`, output, WIDTH: LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch operand magnitudes and the result sign flags; unsigned ops use the raw operands.
  - Load iteration counter = WIDTH; go to RUN; `busy`←1.
- RUN:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring step per cycle; the step is the combinational sub-module.
  - The counter decrements; when it reaches 1, the next state is FIX.
- FIX:
  - Apply sign correction. Quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - Write `hi`/`lo`; `done`←1 for one cycle; `busy`←0; go to IDLE.
- IDLE, `start`=1, MTHI/MTLO: write `a` into `hi`/`lo` on that edge. `busy` stays 0 and `done` stays 0.
- `start` while `busy`=1 is ignored; the pipeline must hold the request.
- Divide by zero (b=0), DIV or DIVU: `lo`=all ones, `hi`=`a`; full latency still applies.
- DIV of the most negative value by −1: `lo`=the most negative value, `hi`=0.
- `flush`=1 in RUN or FIX: go to IDLE next edge; `hi`/`lo` unchanged; `done`=0.
- `flush`=1 together with `start` in IDLE: `start` is ignored.
- Reset (`rst`=0), including mid-operation: state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- Arithmetic width rules:
  - Internal product accumulator is 2·WIDTH bits.
  - Divide partial remainder is WIDTH+1 bits.
  - Counter is $clog2(WIDTH)+1 bits.

## Timing
- Label the edge that samples `start` as E0.
- MULT/DIV: RUN occupies edges E1…E(WIDTH); FIX writes at E(WIDTH+1).
  - `hi`/`lo` are valid, and `done`=1, during the cycle after E(WIDTH+1).
  - Latency is WIDTH+1 edges: 33 for WIDTH=32.
- `busy` is high from after E0 until after E(WIDTH+1), i.e. WIDTH+1 cycles.
- MTHI/MTLO: value visible the cycle after E0.
- A new `start` is accepted on the edge after the `done` cycle begins, i.e. back-to-back with zero bubble.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single combinational WIDTH×WIDTH multiplier; the state path is IDLE→FIX→IDLE.
  - `hi`/`lo` and `done` are valid after E1; `busy` is high for 1 cycle.
  - Divide is unchanged.
- `MDU_FAST_MUL_EN` undefined: iterative multiply as above; no hardware multiplier is inferred.

## Structure
- Package `mdu_pkg` holds:
  - the op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5);
  - the state enum (IDLE, RUN, FIX);
  - a constant for the most negative value, parametrised via function.
- Sub-module `mdu_div_step`: purely combinational; one restoring step (partial remainder, quotient bit in → partial remainder, quotient bit out). It is instantiated once.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` exactly 33 edges after E0; `busy` high for 33 cycles.
- MULT a=0xFFFFFFFD (−3), b=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV a=0xFFFFFFF9 (−7), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7. DIV a=0x80000000, b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Preload `hi`=0x1234 via MTHI (no `busy`). Start DIVU 100/3; assert `flush` at RUN cycle 10 → `busy`=0 next cycle, `hi`=0x1234 retained, no `done`. A `start` issued while busy is ignored.
- `rst`=0 at RUN cycle 5 of MULT → next cycle all outputs are 0. A following MULTU 6×7 completes normally with `lo`=42, `hi`=0.
- With `MDU_FAST_MUL_EN` defined: MULTU 6×7 → `lo`=42 and `done`=1 one edge after E0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, FSM states and width-parametrised constants for the multiply/divide unit
package mdu_pkg;
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] min_val(input int w);
        return MAX_W'(1) << (w - 1);
    endfunction
endpackage

// File: rtl/mdu_div_step.sv
// mdu_div_step: one restoring-division step (shift in a dividend bit, trial-subtract the divisor)
module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);
    logic [WIDTH+1:0] diff;

    always_comb begin
        diff    = {rem_in, bit_in} - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : {rem_in[WIDTH-1:0], bit_in};
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/DIV unit owning HI/LO; defining MDU_FAST_MUL_EN swaps in a single-cycle multiplier
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [MAX_W-1:0] MIN_FULL = min_val(WIDTH);
    localparam logic [WIDTH-1:0] MIN_V = MIN_FULL[WIDTH-1:0];

    state_e state, state_n;
    logic [CW-1:0] cnt;
    logic [2*WIDTH-1:0] acc, acc_init;
    logic [WIDTH:0] rem, rem_n, add;
    logic [WIDTH-1:0] quo, dsr, mag_a, mag_b;
    logic is_div, neg_q, neg_r, div0, ovf, q_bit;
    logic is_mul, is_signed, arith, a_neg, b_neg, fast_mul, go;

    always_comb begin
        is_mul    = op == MULT || op == MULTU;
        is_signed = op == MULT || op == DIV;
        arith     = op <= DIVU;
        a_neg     = is_signed & a[WIDTH-1];
        b_neg     = is_signed & b[WIDTH-1];
        mag_a     = a_neg ? -a : a;
        mag_b     = b_neg ? -b : b;
        go        = state == IDLE && start && !flush;
        add       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : {(WIDTH+1){1'b0}});
    end

`ifdef MDU_FAST_MUL_EN
    assign fast_mul = is_mul;
    assign acc_init = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    assign fast_mul = 1'b0;
    assign acc_init = {{WIDTH{1'b0}}, mag_b};
`endif

    mdu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .bit_in  (quo[WIDTH-1]),
        .divisor (dsr),
        .rem_out (rem_n),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = flush ? IDLE :
                  state == IDLE ? (start && arith ? (fast_mul ? FIX : RUN) : IDLE) :
                  state == RUN  ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            acc    <= '0;
            rem    <= '0;
            quo    <= '0;
            dsr    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            busy <= state_n != IDLE;
            done <= 1'b0;
            if (go) begin
                if (op == MTHI) hi <= a;
                if (op == MTLO) lo <= a;
                if (arith) begin
                    cnt    <= CW'(WIDTH);
                    is_div <= !is_mul;
                    neg_q  <= a_neg ^ b_neg;
                    neg_r  <= a_neg;
                    div0   <= b == '0;
                    ovf    <= op == DIV && a == MIN_V && b == '1;
                    dsr    <= is_mul ? mag_a : mag_b;
                    acc    <= acc_init;
                    rem    <= '0;
                    quo    <= mag_a;
                end
            end else if (state == RUN && !flush) begin
                cnt <= cnt - 1'b1;
                if (is_div) begin
                    rem <= rem_n;
                    quo <= {quo[WIDTH-2:0], q_bit};
                end else begin
                    acc <= {add, acc[WIDTH-1:1]};
                end
            end else if (state == FIX && !flush) begin
                done <= 1'b1;
                if (is_div) begin
                    lo <= div0 ? '1 : ovf ? MIN_V : neg_q ? -quo : quo;
                    hi <= ovf ? '0 : neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                end else begin
                    {hi, lo} <= neg_q ? -acc : acc;
                end
            end
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed checks of mdu_iter results, latency, busy span, MTHI/MTLO, flush and reset
module tb_mdu_iter;
    import mdu_pkg::*;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0] op = 3'd0;
    logic [31:0] a = '0, b = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int n_vec = 0, n_err = 0, lat, bc, dcnt;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or after the bound).
    task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        lat = 0; bc = 0;
        while (lat < 100 && done !== 1'b1) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op_chk(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input int elat);
        run_op(o, x, y);
        chk({tag, ".hi"}, hi, ehi);
        chk({tag, ".lo"}, lo, elo);
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".busy"}, bc, elat);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        rst = 1'b1;

        op_chk("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        op_chk("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        op_chk("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        op_chk("divu_zero", DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 33);
        op_chk("div_zero", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 33);
        op_chk("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
        op_chk("divu", DIVU, 32'd100, 32'd3, 32'd1, 32'd33, 33);

        op = MTHI; a = 32'h1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mthi.hi", hi, 32'h1234);
        chk("mthi.busy", {31'd0, busy}, 32'd0);
        chk("mthi.done", {31'd0, done}, 32'd0);

        op = MTLO; a = 32'h5678; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mtlo.lo", lo, 32'h5678);

        op = MTHI; a = 32'hBEEF; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 begin start = 1'b0; flush = 1'b0; end
        @(negedge clk);
        chk("flush_idle.hi", hi, 32'h1234);
        chk("flush_idle.busy", {31'd0, busy}, 32'd0);

        op = DIVU; a = 32'd100; b = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        op = MTLO; a = 32'hDEAD; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ignore.lo", lo, 32'h5678);
        chk("ignore.busy", {31'd0, busy}, 32'd1);
        repeat (6) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush.busy", {31'd0, busy}, 32'd0);
        chk("flush.hi", hi, 32'h1234);
        chk("flush.lo", lo, 32'h5678);
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) dcnt++;
        end
        chk("flush.no_done", dcnt, 0);

        op = MULT; a = 32'd5; b = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst.busy", {31'd0, busy}, 32'd0);
        chk("midrst.done", {31'd0, done}, 32'd0);
        chk("midrst.hi", hi, 32'd0);
        chk("midrst.lo", lo, 32'd0);

        op_chk("multu_small", MULTU, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
